// File: rtl/exe.sv
// Execute stage: operand forwarding, operand-2 shifter, ALU and NZCV flags,
// EX/MEM pipeline register and branch target generation.
module exe (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_EXE,
  input  logic        MEM_R_EN_EXE,
  input  logic        MEM_W_EN_EXE,
  input  logic        S_EXE,
  input  logic        B_EXE,
  input  logic        imm_EXE,
  input  logic [3:0]  EXE_CMD_EXE,
  input  logic [31:0] pc_EXE,
  input  logic [31:0] rn_val_EXE,
  input  logic [31:0] rm_val_EXE,
  input  logic [11:0] shift_operand_EXE,
  input  logic [23:0] signed_imm_24_EXE,
  input  logic [3:0]  dest_EXE,
  input  logic [1:0]  fwd_sel1,
  input  logic [1:0]  fwd_sel2,
  input  logic [31:0] wb_value_WB,
  output logic        WB_EN_MEM,
  output logic        MEM_R_EN_MEM,
  output logic        MEM_W_EN_MEM,
  output logic [31:0] alu_res_MEM,
  output logic [31:0] rm_val_MEM,
  output logic [3:0]  dest_MEM,
  output logic [3:0]  status,
  output logic        branch_taken,
  output logic [31:0] branch_addr
);

  logic [31:0] val1;
  logic [31:0] rm_fwd;
  logic [31:0] val2;
  logic        mem_op;

  always_comb begin
    unique case (fwd_sel1)
      2'b01:   val1 = alu_res_MEM;
      2'b10:   val1 = wb_value_WB;
      default: val1 = rn_val_EXE;
    endcase
  end

  always_comb begin
    unique case (fwd_sel2)
      2'b01:   rm_fwd = alu_res_MEM;
      2'b10:   rm_fwd = wb_value_WB;
      default: rm_fwd = rm_val_EXE;
    endcase
  end

  assign mem_op = MEM_R_EN_EXE | MEM_W_EN_EXE;

  logic [4:0]  rot_amt;
  logic [63:0] imm_rot;
  logic [4:0]  sh_amt;
  logic [63:0] rm_rot;
  logic [31:0] rm_sh;

  assign rot_amt = {shift_operand_EXE[11:8], 1'b0};
  assign imm_rot = {2{24'b0, shift_operand_EXE[7:0]}} >> rot_amt;
  assign sh_amt  = shift_operand_EXE[11:7];
  assign rm_rot  = {rm_fwd, rm_fwd} >> sh_amt;

  always_comb begin
    unique case (shift_operand_EXE[6:5])
      2'b00:   rm_sh = rm_fwd << sh_amt;
      2'b01:   rm_sh = rm_fwd >> sh_amt;
      2'b10:   rm_sh = $signed(rm_fwd) >>> sh_amt;
      default: rm_sh = rm_rot[31:0];
    endcase
  end

  always_comb begin
    unique case (1'b1)
      mem_op:
        val2 = {20'b0, shift_operand_EXE};
      (!mem_op && imm_EXE):
        val2 = imm_rot[31:0];
      default:
        val2 = rm_sh;
    endcase
  end

  logic [31:0] alu_res;
  logic [31:0] opb;
  logic        cin;
  logic        arith;
  logic        cmd_ok;
  logic [32:0] sum;
  logic [3:0]  nzcv;

  // Subtraction is folded into the adder as val1 + ~val2 + cin
  always_comb begin
    alu_res = '0;
    opb     = val2;
    cin     = 1'b0;
    arith   = 1'b0;
    cmd_ok  = 1'b1;
    nzcv    = status;
    unique case (EXE_CMD_EXE)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010: arith = 1'b1;
      4'b0011: begin
        arith = 1'b1;
        cin   = status[1];
      end
      4'b0100: begin
        arith = 1'b1;
        opb   = ~val2;
        cin   = 1'b1;
      end
      4'b0101: begin
        arith = 1'b1;
        opb   = ~val2;
        cin   = status[1];
      end
      4'b0110: alu_res = val1 & val2;
      4'b0111: alu_res = val1 | val2;
      4'b1000: alu_res = val1 ^ val2;
      default: cmd_ok = 1'b0;
    endcase
    sum = {1'b0, val1} + {1'b0, opb} + {32'b0, cin};
    if (arith)
      alu_res = sum[31:0];
    if (cmd_ok) begin
      nzcv[3] = alu_res[31];
      nzcv[2] = (alu_res == 32'b0);
      if (arith) begin
        nzcv[1] = sum[32];
        nzcv[0] = (val1[31] == opb[31]) &&
                  (alu_res[31] != val1[31]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      MEM_W_EN_MEM <= 1'b0;
      alu_res_MEM  <= '0;
      rm_val_MEM   <= '0;
      dest_MEM     <= '0;
      status       <= '0;
    end else if (!freeze) begin
      WB_EN_MEM    <= WB_EN_EXE;
      MEM_R_EN_MEM <= MEM_R_EN_EXE;
      MEM_W_EN_MEM <= MEM_W_EN_EXE;
      alu_res_MEM  <= alu_res;
      rm_val_MEM   <= rm_fwd;
      dest_MEM     <= dest_EXE;
      if (S_EXE)
        status <= nzcv;
    end
  end

  assign branch_taken = B_EXE;
  assign branch_addr  = pc_EXE +
    {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};

endmodule

// File: tb/tb_exe.sv
// Self-checking bench for exe: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_exe;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE;
  logic        S_EXE, B_EXE, imm_EXE;
  logic [3:0]  EXE_CMD_EXE;
  logic [31:0] pc_EXE, rn_val_EXE, rm_val_EXE;
  logic [11:0] shift_operand_EXE;
  logic [23:0] signed_imm_24_EXE;
  logic [3:0]  dest_EXE;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] wb_value_WB;
  logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
  logic [31:0] alu_res_MEM, rm_val_MEM;
  logic [3:0]  dest_MEM, status;
  logic        branch_taken;
  logic [31:0] branch_addr;

  int checks = 0;
  int errors = 0;

  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_alu, m_rm;
  logic [3:0]  m_dest, m_st;

  exe dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .MEM_W_EN_EXE(MEM_W_EN_EXE), .S_EXE(S_EXE), .B_EXE(B_EXE),
    .imm_EXE(imm_EXE), .EXE_CMD_EXE(EXE_CMD_EXE),
    .pc_EXE(pc_EXE), .rn_val_EXE(rn_val_EXE),
    .rm_val_EXE(rm_val_EXE),
    .shift_operand_EXE(shift_operand_EXE),
    .signed_imm_24_EXE(signed_imm_24_EXE),
    .dest_EXE(dest_EXE), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .wb_value_WB(wb_value_WB),
    .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM),
    .MEM_W_EN_MEM(MEM_W_EN_MEM), .alu_res_MEM(alu_res_MEM),
    .rm_val_MEM(rm_val_MEM), .dest_MEM(dest_MEM),
    .status(status), .branch_taken(branch_taken),
    .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel,
                                       input logic [31:0] reg_v);
    if (sel == 2'b01) return m_alu;
    if (sel == 2'b10) return wb_value_WB;
    return reg_v;
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x,
                                        input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model_val2(input logic [31:0] rmv);
    int n;
    int sx;
    if (MEM_R_EN_EXE || MEM_W_EN_EXE)
      return {20'b0, shift_operand_EXE};
    if (imm_EXE)
      return ror32({24'b0, shift_operand_EXE[7:0]},
                   2 * int'(shift_operand_EXE[11:8]));
    n = int'(shift_operand_EXE[11:7]);
    case (shift_operand_EXE[6:5])
      2'd0: return rmv << n;
      2'd1: return rmv >> n;
      2'd2: begin
        sx = rmv;
        sx = sx >>> n;
        return sx;
      end
      default: return ror32(rmv, n);
    endcase
  endfunction

  // Arithmetic done in 64-bit integers: carry/overflow come from range tests
  task automatic model_alu(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res,
                           output logic [3:0] nf);
    longint ua, ub, sa, sb, u, s;
    int ia, ib;
    int c;
    bit ok, ar, sub;
    ua = a; ub = b;
    ia = a; ib = b;
    sa = ia; sb = ib;
    c = int'(m_st[1]);
    ok = 1; ar = 0; sub = 0;
    res = 0;
    nf = m_st;
    u = 0; s = 0;
    case (EXE_CMD_EXE)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0010: begin ar = 1; u = ua + ub; s = sa + sb; end
      4'b0011: begin ar = 1; u = ua + ub + c; s = sa + sb + c; end
      4'b0100: begin ar = 1; sub = 1; u = ua - ub; s = sa - sb; end
      4'b0101: begin
        ar = 1; sub = 1;
        u = ua - ub - (1 - c);
        s = sa - sb - (1 - c);
      end
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      default: ok = 0;
    endcase
    if (ar) res = u[31:0];
    if (ok) begin
      nf[3] = res[31];
      nf[2] = (res == 0);
      if (ar) begin
        nf[1] = sub ? (u >= 0) : (u >= 64'sh1_0000_0000);
        nf[0] = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
    end
  endtask

  task automatic cycle(input string tag);
    logic [31:0] v1, rmv, v2, res, exp_ba;
    logic [3:0]  nf;
    int off;
    #1;
    off = int'(signed_imm_24_EXE);
    if (off >= 32'h80_0000) off = off - 32'h100_0000;
    exp_ba = pc_EXE + off * 4;
    chk({tag, "_bt"}, {31'b0, branch_taken}, {31'b0, B_EXE});
    chk({tag, "_ba"}, branch_addr, exp_ba);
    v1  = pick(fwd_sel1, rn_val_EXE);
    rmv = pick(fwd_sel2, rm_val_EXE);
    v2  = model_val2(rmv);
    model_alu(v1, v2, res, nf);
    @(posedge clk);
    if (rst) begin
      {m_wb, m_mr, m_mw} = 3'b0;
      m_alu = 0; m_rm = 0; m_dest = 0; m_st = 0;
    end else if (!freeze) begin
      m_wb = WB_EN_EXE; m_mr = MEM_R_EN_EXE; m_mw = MEM_W_EN_EXE;
      m_alu = res; m_rm = rmv; m_dest = dest_EXE;
      if (S_EXE) m_st = nf;
    end
    #1;
    chk({tag, "_ctl"}, {29'b0, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM},
        {29'b0, m_wb, m_mr, m_mw});
    chk({tag, "_alu"}, alu_res_MEM, m_alu);
    chk({tag, "_rm"}, rm_val_MEM, m_rm);
    chk({tag, "_dest"}, {28'b0, dest_MEM}, {28'b0, m_dest});
    chk({tag, "_st"}, {28'b0, status}, {28'b0, m_st});
  endtask

  task automatic nop();
    rst = 0; freeze = 0;
    WB_EN_EXE = 0; MEM_R_EN_EXE = 0; MEM_W_EN_EXE = 0;
    S_EXE = 0; B_EXE = 0; imm_EXE = 0;
    EXE_CMD_EXE = 0; pc_EXE = 0; rn_val_EXE = 0; rm_val_EXE = 0;
    shift_operand_EXE = 0; signed_imm_24_EXE = 0; dest_EXE = 0;
    fwd_sel1 = 0; fwd_sel2 = 0; wb_value_WB = 0;
  endtask

  task automatic rand_in();
    WB_EN_EXE = 1'($urandom);
    MEM_R_EN_EXE = ($urandom_range(0, 5) == 0);
    MEM_W_EN_EXE = ($urandom_range(0, 5) == 0);
    S_EXE = 1'($urandom);
    B_EXE = 1'($urandom);
    imm_EXE = 1'($urandom);
    EXE_CMD_EXE = 4'($urandom);
    pc_EXE = $urandom;
    rn_val_EXE = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
    rm_val_EXE = $urandom;
    shift_operand_EXE = 12'($urandom);
    signed_imm_24_EXE = 24'($urandom);
    dest_EXE = 4'($urandom);
    fwd_sel1 = 2'($urandom);
    fwd_sel2 = 2'($urandom);
    wb_value_WB = $urandom;
  endtask

  initial begin
    m_wb = 0; m_mr = 0; m_mw = 0;
    m_alu = 0; m_rm = 0; m_dest = 0; m_st = 0;
    nop();
    rand_in();
    rst = 1;
    cycle("reset");
    chk("reset_alu", alu_res_MEM, 32'h0);
    chk("reset_st", {28'b0, status}, 32'h0);

    nop();
    EXE_CMD_EXE = 4'b0010; rn_val_EXE = 32'h7FFF_FFFF;
    imm_EXE = 1; shift_operand_EXE = 12'h001; S_EXE = 1;
    WB_EN_EXE = 1; dest_EXE = 4'd3;
    cycle("add_ovf");
    chk("add_ovf_res", alu_res_MEM, 32'h8000_0000);
    chk("add_ovf_nzcv", {28'b0, status}, 32'h9);

    nop();
    EXE_CMD_EXE = 4'b0100; rn_val_EXE = 5;
    imm_EXE = 1; shift_operand_EXE = 12'h005; S_EXE = 1;
    cycle("sub_eq");
    chk("sub_eq_nzcv", {28'b0, status}, 32'h6);
    nop();
    EXE_CMD_EXE = 4'b0011; rn_val_EXE = 1;
    imm_EXE = 1; shift_operand_EXE = 12'h000;
    cycle("adc");
    chk("adc_res", alu_res_MEM, 32'h2);

    nop();
    EXE_CMD_EXE = 4'b0001; imm_EXE = 1; shift_operand_EXE = 12'h4FF;
    cycle("mov_rot");
    chk("mov_rot_res", alu_res_MEM, 32'hFF00_0000);

    nop();
    EXE_CMD_EXE = 4'b0001; imm_EXE = 1; shift_operand_EXE = 12'h055;
    S_EXE = 1;
    cycle("pre_frz");
    for (int i = 0; i < 3; i++) begin
      rand_in();
      freeze = 1; S_EXE = 1; EXE_CMD_EXE = 4'b0010;
      cycle("frz");
      chk("frz_hold", alu_res_MEM, 32'h55);
    end
    nop();
    EXE_CMD_EXE = 4'b0010; rn_val_EXE = 32'h100;
    imm_EXE = 1; shift_operand_EXE = 12'h001;
    cycle("unfrz");
    chk("unfrz_res", alu_res_MEM, 32'h101);

    nop();
    EXE_CMD_EXE = 4'b0001; imm_EXE = 1; shift_operand_EXE = 12'h010;
    cycle("fwd_pre");
    nop();
    EXE_CMD_EXE = 4'b0010; fwd_sel1 = 2'b01; rn_val_EXE = 32'hDEAD;
    imm_EXE = 1; shift_operand_EXE = 12'h004;
    cycle("fwd_mem");
    chk("fwd_mem_res", alu_res_MEM, 32'h14);
    nop();
    EXE_CMD_EXE = 4'b0010; MEM_W_EN_EXE = 1; fwd_sel2 = 2'b10;
    wb_value_WB = 32'hAB; rm_val_EXE = 32'h1234;
    rn_val_EXE = 32'h200; shift_operand_EXE = 12'h008;
    cycle("str");
    chk("str_rm", rm_val_MEM, 32'hAB);
    chk("str_wen", {31'b0, MEM_W_EN_MEM}, 32'h1);
    chk("str_addr", alu_res_MEM, 32'h208);

    nop();
    B_EXE = 1; pc_EXE = 32'h100; signed_imm_24_EXE = 24'hFFFFFE;
    #1;
    chk("br_taken", {31'b0, branch_taken}, 32'h1);
    chk("br_addr", branch_addr, 32'hF8);
    cycle("br");

    rand_in();
    freeze = 1; rst = 1;
    cycle("rst_frz");
    chk("rst_frz_alu", alu_res_MEM, 32'h0);
    chk("rst_frz_rm", rm_val_MEM, 32'h0);
    chk("rst_frz_st", {28'b0, status}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rand_in();
      rst = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe.md
EXE -- requirements
Module: exe

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 SHALL: rst  in  1  synchronous active-high reset.
REQ-004 SHALL: freeze  in  1  hold all EX/MEM and status state this cycle.
REQ-005 SHALL: WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE, imm_EXE  in  1 each  ID/EX control bits.
REQ-006 SHALL: EXE_CMD_EXE  in  4  ALU command.
REQ-007 SHALL: pc_EXE, rn_val_EXE, rm_val_EXE  in  32 each  PC+4, Rn value, Rm value.
REQ-008 SHALL: shift_operand_EXE  in  12  operand-2 field.
REQ-009 SHALL: signed_imm_24_EXE  in  24  branch offset.
REQ-010 SHALL: dest_EXE  in  4  destination register.
REQ-011 SHALL: fwd_sel1, fwd_sel2  in  2 each  operand source: 00 register, 01 alu_res_MEM, 10 wb_value_WB, 11 register.
REQ-012 SHALL: wb_value_WB  in  32  value being written back.
REQ-013 SHALL: WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  out  1 each  registered control to MEM stage.
REQ-014 SHALL: alu_res_MEM, rm_val_MEM  out  32 each  registered ALU result / store data.
REQ-015 SHALL: dest_MEM  out  4  registered destination.
REQ-016 SHALL: status  out  4  registered NZCV, {N,Z,C,V} in bits 3..0.
REQ-017 SHALL: branch_taken  out  1 and branch_addr  out  32, both combinational.

Function
REQ-018 SHALL: Val1 = fwd_sel1 source for Rn; store data = fwd_sel2 source for Rm.
REQ-019 SHALL: Val2 when MEM_R_EN_EXE or MEM_W_EN_EXE: zero-extended shift_operand_EXE[11:0].
REQ-020 SHALL: else if imm_EXE: zero-extended [7:0] rotated right by 2*[11:8].
REQ-021 SHALL: else forwarded Rm shifted by [11:7] per [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 = unshifted.
REQ-022 SHALL: EXE_CMD: 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD; 0011 ADC=+C; 0100 SUB; 0101 SBC=Val1-Val2-(1-C); 0110 AND; 0111 ORR; 1000 EOR; others result 0, flags unchanged.
REQ-023 SHALL: 32-bit wrap-around arithmetic; C = carry out of 33-bit sum (SUB/SBC computed as Val1+~Val2+cin, C=1 means no borrow); V = signed overflow.
REQ-024 SHALL: N=result[31], Z=(result==0); logic/move ops leave C,V at current status.
REQ-025 SHALL: status loads new NZCV at rising edge iff S_EXE=1, freeze=0, rst=0.
REQ-026 SHALL: EX/MEM register loads {WB_EN, MEM_R_EN, MEM_W_EN, ALU result, store data, dest} every edge with freeze=0; holds with freeze=1.
REQ-027 SHALL: branch_taken = B_EXE; branch_addr = pc_EXE + (sign-extended signed_imm_24_EXE << 2), mod 2^32, independent of freeze.
REQ-028 SHALL: forwarding select 01 uses the current registered alu_res_MEM (value before the edge).
REQ-029 SHALL: latency one cycle from EX inputs to *_MEM outputs.

Reset
REQ-030 SHALL: rst=1 at a rising edge clears all *_MEM outputs and status to 0; rst has priority over freeze and S_EXE.
REQ-031 SHALL: reset mid-stream discards the instruction in EX; first post-reset edge loads normally.

Verification
REQ-032 SHALL: ADD, Val1=0x7FFFFFFF, imm Val2=1, S=1 -> alu_res_MEM=0x80000000, status=1001 next cycle.
REQ-033 SHALL: SUB 5-5 S=1 then ADC 1+imm 0 -> first status=0110, ADC result 2.
REQ-034 SHALL: imm_EXE=1, shift_operand=0x4FF -> Val2=0xFF000000; MOV gives alu_res_MEM=0xFF000000.
REQ-035 SHALL: freeze=1 for 3 cycles with changing inputs and S=1 -> outputs and status stay constant; release -> load on next edge.
REQ-036 SHALL: fwd_sel1=01 with alu_res_MEM=0x10, ADD imm 4 -> 0x14; fwd_sel2=10, wb_value_WB=0xAB, STR -> rm_val_MEM=0xAB, MEM_W_EN_MEM=1.
REQ-037 SHALL: B_EXE=1, pc_EXE=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8 same cycle; rst=1 during freeze -> all outputs 0.
